// File: rtl/key_sequencer.sv
// Key front end: debounces and arbitrates 14 synchronized key levels, queues the
// accepted key codes and issues one single-cycle command pulse per key to the core.
module key_sequencer #(
   parameter int DB_CYCLES  = 4,
   parameter int GAP        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [9:0]                  push_in,
   input  logic                        plus_in,
   input  logic                        minus_in,
   input  logic                        equal_in,
   input  logic                        ce_in,
   output logic [9:0]                  push_out,
   output logic                        plus_out,
   output logic                        minus_out,
   output logic                        equal_out,
   output logic                        ce_out,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [3:0] CODE_CE = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    code_q, code_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [13:0]   out_q, out_d;
   logic          drop_q, drop_d;
   logic [3:0]    mem_q [FIFO_DEPTH];

   logic [13:0]   keys;
   logic          any_key;
   logic [3:0]    pri_code;
   logic          accept;
   logic          is_ce;
   logic          empty;
   logic          full;
   logic          pop;
   logic          wr;
   logic [3:0]    head_code;
   logic [13:0]   head_onehot;

   assign keys    = {ce_in, equal_in, minus_in, plus_in, push_in};
   assign any_key = |keys;

   // Later assignments win, so the list runs from lowest to highest priority.
   always_comb begin
      pri_code = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (push_in[i]) begin
            pri_code = 4'(i);
         end
      end
      if (plus_in)  pri_code = 4'd10;
      if (minus_in) pri_code = 4'd11;
      if (equal_in) pri_code = 4'd12;
      if (ce_in)    pri_code = 4'd13;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_key) begin
               code_d  = pri_code;
               cnt_d   = CW'(1);
               state_d = S_DEBOUNCE;
            end
         end
         S_DEBOUNCE: begin
            if (!keys[code_q]) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RELEASE: begin
            // The count here is the run of consecutive all-low samples.
            if (any_key) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign is_ce     = accept && (code_q == CODE_CE);
   assign empty     = (count_q == '0);
   assign full      = (count_q == LW'(FIFO_DEPTH));
   assign pop       = !empty && (gap_q == '0) && !is_ce;
   assign wr        = accept && (is_ce || !full || pop);
   assign head_code = mem_q[rd_ptr_q];

   for (genvar gi = 0; gi < 14; gi++) begin : g_dec
      assign head_onehot[gi] = (head_code == 4'(gi));
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      gap_d    = gap_q;
      out_d    = '0;
      drop_d   = accept && !is_ce && full && !pop;

      if (is_ce) begin
         // Clear discards everything queued; its own code becomes the only entry.
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q + AW'(1);
         count_d  = LW'(1);
      end else begin
         if (wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (wr && !pop) begin
            count_d = count_q + LW'(1);
         end else if (!wr && pop) begin
            count_d = count_q - LW'(1);
         end
      end

      if (pop) begin
         out_d = head_onehot;
         gap_d = GW'(GAP);
      end else if (gap_q != '0) begin
         gap_d = gap_q - GW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         code_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         gap_q    <= '0;
         out_q    <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge CLK) begin
      if (wr) begin
         mem_q[wr_ptr_q] <= code_q;
      end
   end

   assign push_out  = out_q[9:0];
   assign plus_out  = out_q[10];
   assign minus_out = out_q[11];
   assign equal_out = out_q[12];
   assign ce_out    = out_q[13];
   assign busy      = !empty;
   assign level     = count_q;
   assign drop      = drop_q;

endmodule

// File: doc/key_sequencer.md
Name: key_sequencer

Overview:
Front-end controller between the input synchronizers and the calculator core. It takes synchronized key levels (ten digits, plus, minus, equal, ce), debounces them and arbitrates simultaneous presses down to one key per press. Accepted keys are queued in a small FIFO. The core receives exactly one single-cycle command pulse per accepted key, with a guaranteed idle gap between pulses.

Parameters:
DB_CYCLES, 4, consecutive high samples needed to accept a key; also consecutive all-low samples needed to re-arm (min 2)
GAP, 2, idle cycles forced between two issued command pulses (min 0)
FIFO_DEPTH, 4, key-code queue depth, power of two

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-low reset
push_in  input  10  synchronized digit key levels, bit n = digit n, active-high
plus_in  input  1  synchronized plus key level
minus_in  input  1  synchronized minus key level
equal_in  input  1  synchronized equal key level
ce_in  input  1  synchronized clear key level
push_out  output  10  one-hot digit command pulse to core
plus_out  output  1  plus command pulse
minus_out  output  1  minus command pulse
equal_out  output  1  equal command pulse
ce_out  output  1  clear command pulse
busy  output  1  FIFO non-empty
level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy (3 bits at default)
drop  output  1  one-cycle pulse: an accepted key was discarded because the FIFO was full

Behaviour:
- Reset (RST low, async): all outputs 0; FIFO empty; FSM in IDLE; counters 0; gap counter 0.
- Key codes: digit n = n; plus = 10; minus = 11; equal = 12; ce = 13 (4 bits).
- Arbitration priority, highest first: ce, equal, minus, plus, push_in[0] .. push_in[9].
- Accept FSM:
  - IDLE: if any key is high, capture the highest-priority key code, set cnt = 1, go to DEBOUNCE.
  - DEBOUNCE: if the captured key is low, go to IDLE and enqueue nothing. Other keys are ignored in this state. If the captured key is high and cnt = DB_CYCLES-1, accept it (enqueue on this edge) and go to RELEASE. Otherwise increment cnt.
  - RELEASE: count consecutive cycles with all 14 inputs low. On reaching DB_CYCLES, go to IDLE. Any high input resets the count. No new key is accepted while in RELEASE.
- Enqueue:
  - Non-ce key: written if the FIFO is not full or a pop occurs on the same edge. Otherwise it is discarded and drop pulses for one cycle.
  - ce key: flushes the FIFO and writes the ce code, so level = 1 next cycle. It never drops. A pop on the same edge is suppressed and no command pulse is issued on that edge.
- Issue:
  - Pop occurs when the FIFO is non-empty and the gap counter is 0.
  - On the pop edge, the matching output register is set for exactly one cycle (push_out one-hot); all other outputs are 0. The gap counter loads GAP.
  - The gap counter decrements each cycle while non-zero.
  - Consecutive pulses are separated by exactly GAP low cycles when the FIFO stays non-empty.
- Latency: a key first sampled high at edge t0 and held is enqueued at edge t0+DB_CYCLES-1. With an empty FIFO and gap 0, its pulse is high in the cycle after edge t0+DB_CYCLES.
- level and busy update on the same edge as the push/pop. A simultaneous push and pop leaves level unchanged.
- FIFO read/write pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation: queued keys are lost, any in-flight pulse is deasserted immediately, and no pulse is emitted after release of reset until a new press.

Test Plan:
- Single key: push_in[5] high for 10 cycles from edge 0 -> push_out = 10'b0000100000 for exactly one cycle after edge 4; no further pulse; busy high for 1 cycle.
- Glitch reject: plus_in high for 3 cycles, then low -> no plus_out pulse, level stays 0, FSM returns to IDLE.
- Priority: equal_in and push_in[3] rise together and both held -> only equal_out pulses. Releasing equal_in while push_in[3] stays high -> no digit pulse until all keys have been low for 4 cycles and push_in[3] is pressed again.
- Gap/queue: force GAP stall by holding pops; enqueue 4 keys (digits 1,2,3,4) -> level reaches 4; pulses emerge in order 1,2,3,4 with exactly 2 low cycles between them.
- Overflow and clear: FIFO full at level 4, then press minus -> drop pulses once and level stays 4. Then press ce -> level = 1 after acceptance and the next pulse is ce_out only; the queued digits are never issued.
- Async reset: assert RST low while level = 3 and a pulse is high -> all outputs 0 immediately without a clock edge. After release, no pulses appear.
